tdm_serializer: RTL and testbench

TDM_SERIALIZER -- requirements
Module: tdm_serializer

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_serializer.sv | 97 +++++++++
 tb/tb_tdm_serializer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM defaults and state encoding for the serializer and the decimator.
package tdm_pkg;

  localparam int TDM_N_CH           = 8;
  localparam int TDM_DATA_W         = 24;
  localparam int TDM_FRAMES_PER_PKT = 33;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } tdm_state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_serializer.sv
// Parallel-frame to per-channel sample serializer with packet framing on tlast.
module tdm_serializer
  import tdm_pkg::*;
#(
  parameter int N_CH           = TDM_N_CH,
  parameter int DATA_W         = TDM_DATA_W,
  parameter int FRAMES_PER_PKT = TDM_FRAMES_PER_PKT
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_aresetn,
  input  logic [N_CH*DATA_W-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(N_CH)-1:0]    m_axis_tuser,
  output logic                       m_axis_tlast
);

  localparam int CH_W = $clog2(N_CH);
  localparam int FC_W = cnt_w(FRAMES_PER_PKT);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PKT - 1);

  tdm_state_t              state_reg, state_next;
  logic [CH_W-1:0]         ch_reg, ch_next;
  logic [FC_W-1:0]         fcnt_reg, fcnt_next;
  logic [N_CH*DATA_W-1:0]  frame_reg, frame_next;
  logic                    ready_en_reg;

  logic in_hs, out_hs, last_ch;

  assign last_ch = (ch_reg == CH_LAST);
  assign in_hs   = s_axis_tvalid & s_axis_tready;
  assign out_hs  = m_axis_tvalid & m_axis_tready;

  // ready_en keeps tready low through reset and until the first edge after release.
  assign s_axis_tready = ready_en_reg &
                         ((state_reg == EMPTY) ||
                          ((state_reg == SEND) && last_ch && m_axis_tready));

  assign m_axis_tvalid = (state_reg == SEND);
  assign m_axis_tdata  = frame_reg[int'(ch_reg) * DATA_W +: DATA_W];
  assign m_axis_tuser  = ch_reg;
  assign m_axis_tlast  = (state_reg == SEND) && last_ch && (fcnt_reg == FC_LAST);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_reg    <= EMPTY;
      ch_reg       <= '0;
      fcnt_reg     <= '0;
      frame_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      fcnt_reg     <= fcnt_next;
      frame_reg    <= frame_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    fcnt_next  = fcnt_reg;
    frame_next = frame_reg;
    case (state_reg)
      EMPTY: begin
        if (in_hs) begin
          frame_next = s_axis_tdata;
          ch_next    = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (!last_ch) begin
            ch_next = ch_reg + 1'b1;
          end else begin
            fcnt_next = (fcnt_reg == FC_LAST) ? '0 : fcnt_reg + 1'b1;
            ch_next   = '0;
            // Back-to-back frame load avoids a bubble between frames.
            if (in_hs) begin
              frame_next = s_axis_tdata;
            end else begin
              state_next = EMPTY;
            end
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_tdm_serializer.sv
// Directed and randomized stimulus for tdm_serializer with self-checking assertions.
module tb_tdm_serializer;

  localparam int N_CH   = 8;
  localparam int DATA_W = 24;
  localparam int FPP    = 33;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_CH*DATA_W-1:0] s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic [DATA_W-1:0]      m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [2:0]             m_tuser;
  logic                   m_tlast;

  int vectors     = 0;
  int miscompares = 0;
  int out_idx     = 0;
  int send_idx    = 0;
  int tlast_cnt   = 0;

  always #5 clk = ~clk;

  tdm_serializer #(.N_CH(N_CH), .DATA_W(DATA_W), .FRAMES_PER_PKT(FPP)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tuser   (m_tuser),
    .m_axis_tlast   (m_tlast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int f, input int k);
    logic [31:0] v;
    v = f * 16 + k;
    return v[DATA_W-1:0] ^ 24'h5A0000;
  endfunction

  function automatic logic [N_CH*DATA_W-1:0] frame_of(input int f);
    logic [N_CH*DATA_W-1:0] fr;
    for (int k = 0; k < N_CH; k++) fr[k*DATA_W +: DATA_W] = pat(f, k);
    return fr;
  endfunction

  function automatic logic [N_CH*DATA_W-1:0] base_frame(input logic [DATA_W-1:0] base);
    logic [N_CH*DATA_W-1:0] fr;
    for (int k = 0; k < N_CH; k++) fr[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return fr;
  endfunction

  task automatic chk_beat(input string tag, input logic [DATA_W-1:0] data, input int ch);
    chk({tag, "_valid"}, {31'd0, m_tvalid}, 32'd1);
    chk({tag, "_user"}, {29'd0, m_tuser}, ch);
    chk({tag, "_data"}, {8'd0, m_tdata}, {8'd0, data});
    chk({tag, "_last"}, {31'd0, m_tlast}, 32'd0);
  endtask

  // Streams frames frame_of(send_idx) until out_idx reaches target; random or continuous handshakes.
  task automatic stream(input int target, input bit rnd, input int budget);
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    logic [2:0] pu = '0;
    logic pl = 1'b0;
    bit exp_last;
    while (out_idx < target && cyc < budget) begin
      @(negedge clk);
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata  = frame_of(send_idx);
      #1;
      if (prev_stall) begin
        chk("hold_data", {8'd0, m_tdata}, {8'd0, pd});
        chk("hold_user", {29'd0, m_tuser}, {29'd0, pu});
        chk("hold_last", {31'd0, m_tlast}, {31'd0, pl});
      end
      if (!rnd && out_idx > 0) chk("gapless", {31'd0, m_tvalid}, 32'd1);
      if (m_tvalid && m_tuser != 3'(N_CH - 1)) chk("early_accept", {31'd0, s_tready}, 32'd0);
      if (m_tvalid && m_tready) begin
        exp_last = ((out_idx % N_CH) == N_CH - 1) && (((out_idx / N_CH) % FPP) == FPP - 1);
        chk("s_data", {8'd0, m_tdata}, {8'd0, pat(out_idx / N_CH, out_idx % N_CH)});
        chk("s_user", {29'd0, m_tuser}, out_idx % N_CH);
        chk("s_last", {31'd0, m_tlast}, {31'd0, exp_last});
        if (m_tlast) tlast_cnt++;
        out_idx++;
      end
      prev_stall = m_tvalid & ~m_tready;
      pd = m_tdata;
      pu = m_tuser;
      pl = m_tlast;
      if (s_tvalid && s_tready) send_idx++;
      cyc++;
    end
    chk("budget", {31'd0, out_idx >= target}, 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    s_tdata  = '0;

    // Reset state
    #2;
    chk("rst_valid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_data", {8'd0, m_tdata}, 32'd0);
    chk("rst_user", {29'd0, m_tuser}, 32'd0);
    chk("rst_last", {31'd0, m_tlast}, 32'd0);
    chk("rst_sready", {31'd0, s_tready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_sready0", {31'd0, s_tready}, 32'd0);
    @(negedge clk);
    #1 chk("rel_sready1", {31'd0, s_tready}, 32'd1);

    // Single frame, free-flowing output
    s_tdata  = base_frame(24'h100000);
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      #1 chk_beat("one", 24'h100000 + 24'(k), k);
      if (k == 0) chk("one_sready", {31'd0, s_tready}, 32'd0);
      @(negedge clk);
    end
    #1 chk("one_idle", {31'd0, m_tvalid}, 32'd0);

    // Downstream stall on channel 3
    s_tdata  = base_frame(24'h200000);
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (k == 3) begin
        m_tready = 1'b0;
        repeat (5) begin
          #1 chk_beat("stall", 24'h200003, 3);
          chk("stall_sready", {31'd0, s_tready}, 32'd0);
          @(negedge clk);
        end
        m_tready = 1'b1;
      end
      #1 chk_beat("stall_run", 24'h200000 + 24'(k), k);
      @(negedge clk);
    end
    #1 chk("stall_idle", {31'd0, m_tvalid}, 32'd0);

    // Input held off on the last channel until downstream accepts it
    s_tdata  = base_frame(24'h300000);
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int k = 0; k < N_CH - 1; k++) begin
      #1 chk_beat("hold", 24'h300000 + 24'(k), k);
      @(negedge clk);
    end
    m_tready = 1'b0;
    s_tdata  = base_frame(24'h400000);
    s_tvalid = 1'b1;
    repeat (3) begin
      #1 chk_beat("ch7_wait", 24'h300007, 7);
      chk("ch7_sready", {31'd0, s_tready}, 32'd0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    #1 chk("ch7_sready_go", {31'd0, s_tready}, 32'd1);
    chk_beat("ch7_go", 24'h300007, 7);
    @(negedge clk);
    s_tvalid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      #1 chk_beat("next", 24'h400000 + 24'(k), k);
      @(negedge clk);
    end
    #1 chk("next_idle", {31'd0, m_tvalid}, 32'd0);

    // Fresh packet, then asynchronous reset at frame 10 channel 4
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_idx = 0; send_idx = 0; tlast_cnt = 0;
    stream(10 * N_CH + 4, 1'b0, 200);
    @(posedge clk);
    #2;
    chk("pre_rst_user", {29'd0, m_tuser}, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_data", {8'd0, m_tdata}, 32'd0);
    chk("arst_user", {29'd0, m_tuser}, 32'd0);
    chk("arst_last", {31'd0, m_tlast}, 32'd0);
    chk("arst_sready", {31'd0, s_tready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_idx = 0; send_idx = 0; tlast_cnt = 0;

    // Two full packets of continuous traffic
    stream(2 * N_CH * FPP, 1'b0, 600);
    chk("cont_tlast_cnt", tlast_cnt, 32'd2);

    // Random handshakes on both sides
    @(negedge clk);
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    #1 chk("rst2_valid", {31'd0, m_tvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_idx = 0; send_idx = 0; tlast_cnt = 0;
    stream(2000, 1'b1, 20000);
    chk("rand_tlast_cnt", tlast_cnt, 2000 / (N_CH * FPP));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
